branch_direction_predictor: RTL and testbench

- Gshare direction predictor in the fetch stage, alongside the BTB.
- Combines the BTB hit with a 2-bit saturating pattern history table (PHT) to produce the taken prediction that drives next-PC selection.
- Trains from execute-stage branch resolution, keeps a non-speculative global history register (GHR), flags mispredictions and counts branches and mispredictions.
- Its branchPredictedE result feeds the BTB's branchPredictedE input.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/branch_direction_predictor_if.sv | 36 +++
 rtl/sat_counter2.sv | 25 ++
 rtl/branch_direction_predictor.sv | 87 ++++++++
 tb/tb_branch_direction_predictor.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the gshare direction predictor.
// Revision    : 1.0
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e PHT_INIT = WNT;

    // The index is taken from the PC above the instruction byte offset.
    localparam int C_IDX_LSB   = 2;
    localparam int C_W_PC_DEF  = 8;
    localparam int C_W_IDX_DEF = 4;
    localparam int C_W_GHR_DEF = 4;
    localparam int C_W_CNT_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/branch_direction_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_direction_predictor_if
// Description : Fetch/execute signal bundle between pipeline and predictor.
// Revision    : 1.0
// ============================================================================
interface branch_direction_predictor_if #(
    parameter int W_PC  = 8,
    parameter int W_GHR = 4,
    parameter int W_CNT = 16
);
    logic [W_PC-1:0]  pcF;
    logic             btbHitF;
    logic             predictTakenF;
    logic [W_GHR-1:0] ghrF;
    logic             branchE;
    logic             stallE;
    logic [W_PC-1:0]  pcE;
    logic [W_GHR-1:0] ghrE;
    logic             branchTakenE;
    logic             branchPredictedE;
    logic             mispredictE;
    logic [W_CNT-1:0] branchCount;
    logic [W_CNT-1:0] mispredictCount;

    modport master (
        output pcF, btbHitF, branchE, stallE, pcE, ghrE, branchTakenE, branchPredictedE,
        input  predictTakenF, ghrF, mispredictE, branchCount, mispredictCount
    );

    modport slave (
        input  pcF, btbHitF, branchE, stallE, pcE, ghrE, branchTakenE, branchPredictedE,
        output predictTakenF, ghrF, mispredictE, branchCount, mispredictCount
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Next-state function of a 2-bit saturating direction counter.
// Revision    : 1.0
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e state_i,
    input  logic taken_i,
    output ctr_e next_o
);

    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            if (state_i != ST) next_o = ctr_e'(state_i + 2'd1);
        end else begin
            if (state_i != SNT) next_o = ctr_e'(state_i - 2'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_direction_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_direction_predictor
// Description : Gshare direction predictor with non-speculative GHR and
//               saturating branch / mispredict performance counters.
// Revision    : 1.0
// ============================================================================
module branch_direction_predictor
    import bp_pkg::*;
#(
    parameter int W_PC  = C_W_PC_DEF,
    parameter int W_IDX = C_W_IDX_DEF,
    parameter int W_GHR = C_W_GHR_DEF,   // must not exceed W_IDX
    parameter int W_CNT = C_W_CNT_DEF
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    branch_direction_predictor_if.slave bus
);

    localparam int C_PHT_DEPTH = 1 << W_IDX;

    ctr_e             pht_q [C_PHT_DEPTH];
    logic [W_GHR-1:0] ghr_q, ghr_d;
    logic [W_CNT-1:0] bcnt_q, bcnt_d;
    logic [W_CNT-1:0] mcnt_q, mcnt_d;

    logic [W_IDX-1:0] w_idx_f;
    logic [W_IDX-1:0] w_idx_e;
    logic             w_upd_e;
    logic             w_mis_e;
    ctr_e             w_pht_cur;
    ctr_e             w_pht_nxt;
    logic             w_unused;

    assign w_idx_f = bus.pcF[W_IDX+C_IDX_LSB-1:C_IDX_LSB] ^ W_IDX'(ghr_q);
    assign w_idx_e = bus.pcE[W_IDX+C_IDX_LSB-1:C_IDX_LSB] ^ W_IDX'(bus.ghrE);

    // Including reset in the enable keeps outputs quiet while reset is held.
    assign w_upd_e = bus.branchE & ~bus.stallE & reset;
    assign w_mis_e = w_upd_e & (bus.branchTakenE != bus.branchPredictedE);

    assign bus.predictTakenF   = bus.btbHitF & reset & pht_q[w_idx_f][1];
    assign bus.ghrF            = ghr_q;
    assign bus.mispredictE     = w_mis_e;
    assign bus.branchCount     = bcnt_q;
    assign bus.mispredictCount = mcnt_q;

    assign w_pht_cur = pht_q[w_idx_e];

    sat_counter2 u_sat_counter2 (
        .state_i (w_pht_cur),
        .taken_i (bus.branchTakenE),
        .next_o  (w_pht_nxt)
    );

    always_comb begin
        ghr_d  = ghr_q;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (w_upd_e) begin
            ghr_d = (ghr_q << 1) | W_GHR'(bus.branchTakenE);
            if (~&bcnt_q) bcnt_d = bcnt_q + W_CNT'(1);
            if (w_mis_e && ~&mcnt_q) mcnt_d = mcnt_q + W_CNT'(1);
        end
    end

    // Fetch reads the registered array, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_PHT_DEPTH; i++) pht_q[i] <= PHT_INIT;
            ghr_q  <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (w_upd_e) pht_q[w_idx_e] <= w_pht_nxt;
            ghr_q  <= ghr_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign w_unused = &{1'b0, bus.pcF[C_IDX_LSB-1:0], bus.pcE[C_IDX_LSB-1:0],
                        bus.pcF[W_PC-1:W_IDX+C_IDX_LSB], bus.pcE[W_PC-1:W_IDX+C_IDX_LSB]};

endmodule
`default_nettype wire

// File: tb/tb_branch_direction_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_direction_predictor
// Description : Directed bench with an abstract gshare model and literal pins.
// Revision    : 1.0
// ============================================================================
module tb_branch_direction_predictor;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_mis;

    int m_pht [16];
    int m_ghr;
    int m_bc;
    int m_mc;

    branch_direction_predictor_if #(.W_PC(8), .W_GHR(4), .W_CNT(16)) bus ();

    branch_direction_predictor #(
        .W_PC  (8),
        .W_IDX (4),
        .W_GHR (4),
        .W_CNT (16)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_idx(input int pc, input int h);
        return ((pc / 4) % 16) ^ (h % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n && bus.branchE && !bus.stallE) begin
            int k;
            k = model_idx(int'(bus.pcE), int'(bus.ghrE));
            if (bus.branchTakenE) m_pht[k] = (m_pht[k] < 3) ? m_pht[k] + 1 : 3;
            else                  m_pht[k] = (m_pht[k] > 0) ? m_pht[k] - 1 : 0;
            m_ghr = (m_ghr * 2 + int'(bus.branchTakenE)) % 16;
            if (m_bc < 65535) m_bc = m_bc + 1;
            if (bus.branchTakenE != bus.branchPredictedE && m_mc < 65535) m_mc = m_mc + 1;
        end
    end

    // Per-cycle comparison against the model, inside the low clock phase.
    always @(negedge clk) begin
        #3;
        begin
            int  k;
            bit  exp_pred;
            bit  exp_mis;
            k        = model_idx(int'(bus.pcF), m_ghr);
            exp_pred = rst_n && bus.btbHitF && (m_pht[k] >= 2);
            exp_mis  = rst_n && bus.branchE && !bus.stallE &&
                       (bus.branchTakenE != bus.branchPredictedE);
            chk("model.predictTakenF", longint'(bus.predictTakenF), longint'(exp_pred));
            chk("model.ghrF", longint'(bus.ghrF), longint'(m_ghr));
            chk("model.mispredictE", longint'(bus.mispredictE), longint'(exp_mis));
            chk("model.branchCount", longint'(bus.branchCount), longint'(m_bc));
            chk("model.mispredictCount", longint'(bus.mispredictCount), longint'(m_mc));
        end
    end

    task automatic drive(input logic [7:0] pcf, input logic btb, input logic br,
                         input logic stall, input logic [7:0] pce, input logic [3:0] ghre,
                         input logic tk, input logic pr);
        @(negedge clk);
        bus.pcF              = pcf;
        bus.btbHitF          = btb;
        bus.branchE          = br;
        bus.stallE           = stall;
        bus.pcE              = pce;
        bus.ghrE             = ghre;
        bus.branchTakenE     = tk;
        bus.branchPredictedE = pr;
        #4;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        model_reset();
        rst_n                = 1'b0;
        bus.pcF              = 8'h10;
        bus.btbHitF          = 1'b1;
        bus.branchE          = 1'b0;
        bus.stallE           = 1'b0;
        bus.pcE              = 8'h00;
        bus.ghrE             = 4'h0;
        bus.branchTakenE     = 1'b0;
        bus.branchPredictedE = 1'b0;

        repeat (2) @(negedge clk);
        #4;
        chk("in_reset.predictTakenF", longint'(bus.predictTakenF), 0);
        chk("in_reset.ghrF", longint'(bus.ghrF), 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(8'h10, 1, 0, 0, 8'h00, 4'h0, 0, 0);
        chk("post_reset.predictTakenF", longint'(bus.predictTakenF), 0);
        chk("post_reset.branchCount", longint'(bus.branchCount), 0);
        chk("post_reset.mispredictCount", longint'(bus.mispredictCount), 0);

        drive(8'h10, 1, 1, 0, 8'h10, 4'h0, 1, 0);
        chk("train1.mispredictE", longint'(bus.mispredictE), 1);
        drive(8'h10, 1, 1, 0, 8'h10, 4'h0, 1, 0);

        drive(8'h10, 1, 0, 0, 8'h00, 4'h0, 0, 0);
        chk("alias.ghrF", longint'(bus.ghrF), 3);
        chk("alias.predictTakenF_idx7", longint'(bus.predictTakenF), 0);
        drive(8'h1C, 1, 0, 0, 8'h00, 4'h0, 0, 0);
        chk("entry4.predictTakenF", longint'(bus.predictTakenF), 1);
        drive(8'h1C, 0, 0, 0, 8'h00, 4'h0, 0, 0);
        chk("btb_miss.predictTakenF", longint'(bus.predictTakenF), 0);

        for (int i = 0; i < 5; i++) drive(8'h20, 0, 1, 0, 8'h20, 4'h0, 0, 0);
        for (int i = 0; i < 5; i++) drive(8'h20, 0, 1, 0, 8'h20, 4'h0, 1, 1);
        drive(8'h1C, 1, 0, 0, 8'h00, 4'h0, 0, 0);
        chk("sat.predictTakenF_idx8", longint'(bus.predictTakenF), 1);
        chk("sat.branchCount", longint'(bus.branchCount), 12);
        chk("sat.mispredictCount", longint'(bus.mispredictCount), 2);
        chk("sat.ghrF", longint'(bus.ghrF), 15);

        drive(8'h00, 0, 1, 0, 8'h20, 4'h0, 1, 0);
        chk("mis.mispredictE", longint'(bus.mispredictE), 1);
        drive(8'h00, 0, 1, 1, 8'h20, 4'h0, 1, 0);
        chk("stall.mispredictE", longint'(bus.mispredictE), 0);
        drive(8'h00, 0, 0, 0, 8'h20, 4'h0, 1, 0);
        chk("stall.branchCount", longint'(bus.branchCount), 13);
        chk("stall.mispredictCount", longint'(bus.mispredictCount), 3);

        drive(8'h34, 1, 1, 0, 8'h08, 4'h0, 1, 1);
        chk("rw_same.predictTakenF_old", longint'(bus.predictTakenF), 0);
        drive(8'h34, 1, 0, 0, 8'h08, 4'h0, 0, 0);
        chk("rw_same.predictTakenF_new", longint'(bus.predictTakenF), 1);

        for (int i = 0; i < 24; i++) begin
            drive(8'((i * 20) + 4), (i % 4) != 3, (i % 3) != 0, (i % 5) == 0,
                  8'(i * 12), 4'((i * 7) % 16), (i % 2) == 1, ((i / 2) % 2) == 1);
        end

        drive(8'h08, 1, 1, 0, 8'h08, 4'h0, 1, 0);
        rst_n = 1'b0;
        #0.5;
        chk("async_rst.predictTakenF", longint'(bus.predictTakenF), 0);
        chk("async_rst.ghrF", longint'(bus.ghrF), 0);
        chk("async_rst.mispredictE", longint'(bus.mispredictE), 0);
        chk("async_rst.branchCount", longint'(bus.branchCount), 0);
        chk("async_rst.mispredictCount", longint'(bus.mispredictCount), 0);
        @(negedge clk);
        bus.branchE = 1'b0;
        rst_n       = 1'b1;
        drive(8'h08, 1, 0, 0, 8'h08, 4'h0, 0, 0);
        chk("after_rst.predictTakenF", longint'(bus.predictTakenF), 0);
        chk("after_rst.branchCount", longint'(bus.branchCount), 0);
        chk("after_rst.ghrF", longint'(bus.ghrF), 0);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
